countdown_timer: RTL and testbench
==================================

# countdown_timer

Countdown-timer mode for the alarm-clock board and the counting-down counterpart of the stopwatch mode. The user loads an MM:SS value with buttons, starts it, and the block decrements it once per second. On reaching 00:00 it asserts `ring` for a fixed number of seconds. It drives the shared 4-digit multiplexed seven-segment display while `en` (mode select) is high. Button inputs arrive already debounced and edge-detected as single-cycle pulses.

## Interface
- `CLK_FREQ`, 50000000: input clock frequency in Hz.
- `TICK_HZ`, 1: countdown rate; one decrement per tick.
- `SCAN_HZ`, 500: digit-scan rate.
- `RING_TICKS`, 10: number of ticks `ring` stays high after expiry.
- `clk`  in  1: system clock; all state is on the posedge.
- `rst`  in  1: reset, **asynchronous, active-low**; clears everything.
- `en`  in  1: mode enable; low freezes the block and blanks the display.
- `inc_min`  in  1: pulse; minutes +1, wraps 59→00. Honoured in IDLE only.
- `inc_sec`  in  1: pulse; seconds +1, wraps 59→00 with no carry into minutes. Honoured in IDLE only.
- `start`  in  1: pulse; start/pause toggle.
- `clr`  in  1: pulse; abort and return to IDLE with 00:00.
- `y`  out  7: segments {g..a}, active-low.
- `an_n`  out  4: digit anodes, active-low; bit3 = M tens, bit0 = S ones.
- `ring`  out  1: alarm request to the buzzer driver.

## Operation
- Value is held as four BCD digits: m1 (0–5), m0 (0–9), s1 (0–5), s0 (0–9).
- Decrement uses a borrow chain s0→s1→m0→m1: s0 0→9 borrows from s1; s1 0→5 borrows from m0; m0 0→9 borrows from m1.
- States: IDLE, RUN, PAUSE, RING. Reset state is IDLE, value 00:00.
- IDLE
  - `inc_min`/`inc_sec` edit the value.
  - `start` with value ≠ 00:00 → RUN.
  - `start` with value = 00:00 is ignored.
- RUN
  - Each tick decrements the value.
  - The tick that produces 00:00 → RING on the same edge.
  - `start` → PAUSE.
- PAUSE
  - Value is held.
  - `start` → RUN.
- RING
  - `ring` = 1; the value stays 00:00.
  - After RING_TICKS ticks → IDLE.
  - A `start` or `clr` pulse ends RING immediately → IDLE.
- `clr` in any state → IDLE, value 00:00, `ring` = 0. `clr` wins over any simultaneous pulse.
- `inc_*` pulses in RUN, PAUSE or RING are ignored.
- `en` = 0:
  - State, value and tick prescaler are frozen.
  - All input pulses are ignored.
  - `an_n` = 4'b1111, `y` = 7'b1111111.
  - `ring` keeps its value. The alarm is still heard outside the mode, but the RING duration count is frozen.

## Timing
- Tick: internal prescaler, period DIV = CLK_FREQ/TICK_HZ clk cycles; `tick` is a one-cycle strobe.
  - The prescaler is cleared on the edge that enters RUN (from IDLE or PAUSE).
  - The first decrement therefore lands exactly DIV cycles after the `start` edge.
  - Pausing discards the partial tick.
- Scan: a free-running prescaler, period CLK_FREQ/SCAN_HZ, rotates a one-hot digit select.
  - Order: m1, m0, s1, s0, repeat.
  - The select resets to m1.
  - `y` is the decode of the selected digit, combinational from registered state.
- Input pulses take effect on the clk edge where they are sampled high. State and `ring` change on that same edge: one-cycle latency, visible the next cycle.
- Reset values: state IDLE; digits 0; `ring` 0; `an_n` 4'b0111 (m1 selected); `y` = segments for "0". When `en` = 0, `an_n` and `y` are blanked.
- Tick and `start` on the same edge in RUN: PAUSE is entered and the decrement is still applied.
- Reset asserted mid-RUN or mid-RING: immediate return to reset values with no clock needed.

## Test plan
Use CLK_FREQ=1000, TICK_HZ=100 (DIV=10), SCAN_HZ=250 (period 4), RING_TICKS=3.
- Reset, then `inc_sec`×3, `inc_min`×1 → value 01:03 and `an_n` cycles 0111→1011→1101→1110 every 4 clks; `y` shows 1, 0, 3 for the m0/s1/s0 digits respectively.
- Set 01:00, `start` → exactly 10 clks later value 00:59; after 60 ticks `ring`=1 and the value is 00:00; 30 clks later `ring`=0 and the state is IDLE.
- Set 00:05, `start`, `start` after 25 clks → value 00:03 held for 100 clks; `start` → next decrement 10 clks later gives 00:02.
- `inc_sec` at 59 → 00 with minutes unchanged; `start` at 00:00 → stays IDLE with no ticks applied; `inc_min` during RUN → ignored.
- In RING, pulse `start` → `ring` drops next cycle and the state is IDLE; in RUN, `clr` together with `start` → IDLE, 00:00.
- In RUN, drop `en` for 50 clks → blank display and frozen value; raise `en` → countdown resumes from the prescaler position it was frozen at; assert `rst` low mid-RUN → all outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control pulses, mode enable and display/alarm outputs of the countdown timer.
interface countdown_timer_if;
    logic       en;
    logic       inc_min;
    logic       inc_sec;
    logic       start;
    logic       clr;
    logic [6:0] y;
    logic [3:0] an_n;
    logic       ring;

    modport master (
        output en, inc_min, inc_sec, start, clr,
        input  y, an_n, ring
    );

    modport slave (
        input  en, inc_min, inc_sec, start, clr,
        output y, an_n, ring
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with BCD digits, tick prescaler, ring window and
// a 4-digit multiplexed seven-segment display driver.
module countdown_timer #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned SCAN_HZ    = 500,
    parameter int unsigned RING_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);

    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned SP  = CLK_FREQ / SCAN_HZ;
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = (SP > 1) ? $clog2(SP) : 1;
    localparam int unsigned RCW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

    state_t         state;
    logic [3:0]     m1, m0, s1, s0;
    logic [TW-1:0]  tcnt;
    logic [RCW-1:0] rcnt;
    logic           ring_q;
    logic [SW-1:0]  scnt;
    logic [3:0]     sel;

    logic           tick;
    logic           is_zero;
    logic [3:0]     dm1, dm0, ds1, ds0;
    logic           dec_zero;
    logic [3:0]     im1, im0, is1, is0;
    logic [3:0]     digit;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign tick    = (tcnt == TW'(DIV - 1));
    assign is_zero = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd0);

    // Borrow-chain decrement of the BCD value.
    always_comb begin
        dm1 = m1;
        dm0 = m0;
        ds1 = s1;
        ds0 = s0;
        if (s0 != 4'd0) begin
            ds0 = s0 - 4'd1;
        end else begin
            ds0 = 4'd9;
            if (s1 != 4'd0) begin
                ds1 = s1 - 4'd1;
            end else begin
                ds1 = 4'd5;
                if (m0 != 4'd0) begin
                    dm0 = m0 - 4'd1;
                end else begin
                    dm0 = 4'd9;
                    dm1 = m1 - 4'd1;
                end
            end
        end
        dec_zero = (dm1 == 4'd0) && (dm0 == 4'd0) && (ds1 == 4'd0) && (ds0 == 4'd0);
    end

    // Independent minute and second increments, each wrapping 59 -> 00.
    always_comb begin
        im1 = m1;
        im0 = m0 + 4'd1;
        if (m0 == 4'd9) begin
            im0 = 4'd0;
            im1 = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
        end
        is1 = s1;
        is0 = s0 + 4'd1;
        if (s0 == 4'd9) begin
            is0 = 4'd0;
            is1 = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
        end
    end

    // Mode FSM with value, tick prescaler and ring duration; frozen while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            m1     <= '0;
            m0     <= '0;
            s1     <= '0;
            s0     <= '0;
            tcnt   <= '0;
            rcnt   <= '0;
            ring_q <= 1'b0;
        end else if (bus.en) begin
            if (bus.clr) begin
                state  <= IDLE;
                m1     <= '0;
                m0     <= '0;
                s1     <= '0;
                s0     <= '0;
                tcnt   <= '0;
                rcnt   <= '0;
                ring_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.inc_min) begin
                            m1 <= im1;
                            m0 <= im0;
                        end
                        if (bus.inc_sec) begin
                            s1 <= is1;
                            s0 <= is0;
                        end
                        if (bus.start && !is_zero) begin
                            state <= RUN;
                            tcnt  <= '0;
                        end
                    end
                    RUN: begin
                        tcnt <= tick ? '0 : tcnt + TW'(1);
                        // Expiry takes precedence over a coincident pause request.
                        if (tick) begin
                            m1 <= dm1;
                            m0 <= dm0;
                            s1 <= ds1;
                            s0 <= ds0;
                            if (dec_zero) begin
                                state  <= RING;
                                ring_q <= 1'b1;
                                rcnt   <= '0;
                            end else if (bus.start) begin
                                state <= PAUSE;
                            end
                        end else if (bus.start) begin
                            state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (bus.start) begin
                            state <= RUN;
                            tcnt  <= '0;
                        end
                    end
                    RING: begin
                        tcnt <= tick ? '0 : tcnt + TW'(1);
                        if (bus.start) begin
                            state  <= IDLE;
                            ring_q <= 1'b0;
                        end else if (tick) begin
                            if (rcnt == RCW'(RING_TICKS - 1)) begin
                                state  <= IDLE;
                                ring_q <= 1'b0;
                            end else begin
                                rcnt <= rcnt + RCW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Free-running scan prescaler rotating a one-hot digit select m1 -> s0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= '0;
            sel  <= 4'b1000;
        end else if (scnt == SW'(SP - 1)) begin
            scnt <= '0;
            sel  <= {sel[0], sel[3:1]};
        end else begin
            scnt <= scnt + SW'(1);
        end
    end

    // Selected digit for the segment decoder.
    always_comb begin
        case (sel)
            4'b1000: digit = m1;
            4'b0100: digit = m0;
            4'b0010: digit = s1;
            default: digit = s0;
        endcase
    end

    assign bus.an_n = bus.en ? ~sel : 4'b1111;
    assign bus.y    = bus.en ? seg_of(digit) : 7'b1111111;
    assign bus.ring = ring_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a seconds-based reference model.
module tb_countdown_timer;

    localparam int unsigned P_CLK  = 1000;
    localparam int unsigned P_TICK = 100;
    localparam int unsigned P_SCAN = 250;
    localparam int unsigned P_RING = 3;
    localparam int DIV    = P_CLK / P_TICK;
    localparam int SCAN_P = P_CLK / P_SCAN;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_RING} mstate_t;

    logic clk;
    logic rst;
    countdown_timer_if tb_bus ();

    countdown_timer #(
        .CLK_FREQ   (P_CLK),
        .TICK_HZ    (P_TICK),
        .SCAN_HZ    (P_SCAN),
        .RING_TICKS (P_RING)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: value as whole minutes and seconds
    mstate_t m_st;
    int      m_min, m_sec;
    int      m_phase, m_rt, scan_k;
    logic    m_ring;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] lit_segs(input int d);
        logic [6:0] on;
        case (d)
            0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
            5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; default: on = 7'h6F;
        endcase
        return ~on;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_min = 0; m_sec = 0; m_ring = 1'b0;
        m_phase = 0; m_rt = 0; scan_k = 0;
    endtask

    task automatic model_edge(input logic e, input logic pm, input logic ps,
                              input logic pst, input logic pcl);
        int  total;
        logic t;
        scan_k++;
        if (!e) return;
        if (pcl) begin
            m_st = M_IDLE; m_min = 0; m_sec = 0; m_ring = 1'b0;
            return;
        end
        case (m_st)
            M_IDLE: begin
                total = m_min * 60 + m_sec;
                if (pm) m_min = (m_min + 1) % 60;
                if (ps) m_sec = (m_sec + 1) % 60;
                if (pst && total != 0) begin m_st = M_RUN; m_phase = 0; end
            end
            M_RUN: begin
                m_phase++;
                t = (m_phase == DIV);
                if (t) begin
                    m_phase = 0;
                    total = m_min * 60 + m_sec - 1;
                    m_min = total / 60;
                    m_sec = total % 60;
                    if (total == 0) begin m_st = M_RING; m_ring = 1'b1; m_rt = 0; end
                    else if (pst) m_st = M_PAUSE;
                end else if (pst) m_st = M_PAUSE;
            end
            M_PAUSE: if (pst) begin m_st = M_RUN; m_phase = 0; end
            M_RING: begin
                m_phase++;
                t = (m_phase == DIV);
                if (t) m_phase = 0;
                if (pst) begin m_st = M_IDLE; m_ring = 1'b0; end
                else if (t) begin
                    m_rt++;
                    if (m_rt == P_RING) begin m_st = M_IDLE; m_ring = 1'b0; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_outputs(input logic e);
        int idx, d;
        logic [3:0] exp_an;
        logic [6:0] exp_y;
        idx = (scan_k / SCAN_P) % 4;
        case (idx)
            0: d = m_min / 10;
            1: d = m_min % 10;
            2: d = m_sec / 10;
            default: d = m_sec % 10;
        endcase
        exp_an = e ? ~(4'b1000 >> idx) : 4'b1111;
        exp_y  = e ? lit_segs(d) : 7'b1111111;
        check("an_n", 32'(tb_bus.an_n), 32'(exp_an));
        check("y",    32'(tb_bus.y),    32'(exp_y));
        check("ring", 32'(tb_bus.ring), 32'(m_ring));
    endtask

    // one clock with the given inputs held across the edge, checked 1 time unit after
    task automatic step(input logic e, input logic pm, input logic ps,
                        input logic pst, input logic pcl);
        tb_bus.en = e; tb_bus.inc_min = pm; tb_bus.inc_sec = ps;
        tb_bus.start = pst; tb_bus.clr = pcl;
        @(posedge clk);
        model_edge(e, pm, ps, pst, pcl);
        #1;
        compare_outputs(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_sec(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_start();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic press_clr();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // called 1 unit after a posedge: asynchronous assert, check without a clock, release before next edge
    task automatic async_reset();
        #3 rst = 1'b0;
        tb_bus.en = 1'b1; tb_bus.inc_min = 1'b0; tb_bus.inc_sec = 1'b0;
        tb_bus.start = 1'b0; tb_bus.clr = 1'b0;
        #1;
        model_reset();
        check("rst_an_n", 32'(tb_bus.an_n), 32'(4'b0111));
        check("rst_y",    32'(tb_bus.y),    32'(7'b1000000));
        check("rst_ring", 32'(tb_bus.ring), 32'(1'b0));
        #2 rst = 1'b1;
    endtask

    initial begin
        int r, p;
        logic e, pm, ps, pst, pcl;
        rst = 1'b1;
        tb_bus.en = 1'b1; tb_bus.inc_min = 1'b0; tb_bus.inc_sec = 1'b0;
        tb_bus.start = 1'b0; tb_bus.clr = 1'b0;
        model_reset();
        #6;
        async_reset();

        // 01:03 and the display scan
        press_sec(3);
        press_min(1);
        idle(16);

        // 01:00 runs out, rings for three ticks, returns to idle
        press_clr();
        press_min(1);
        press_start();
        idle(640);

        // 00:05 paused after 25 clks, held, resumed
        press_clr();
        press_sec(5);
        press_start();
        idle(24);
        press_start();
        idle(100);
        press_start();
        idle(15);

        // seconds wrap without carry, start at zero ignored, inc during run ignored
        press_clr();
        press_min(1);
        press_sec(60);
        press_clr();
        press_start();
        idle(20);
        press_sec(1);
        press_start();
        press_min(1);
        idle(5);

        // ring cut short by start; clr beats simultaneous start
        press_clr();
        press_sec(1);
        press_start();
        idle(12);
        press_start();
        idle(3);
        press_sec(2);
        press_start();
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // en freeze mid-run, then asynchronous reset mid-run
        press_clr();
        press_sec(30);
        press_start();
        idle(15);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(25);
        async_reset();
        idle(8);

        // randomized operation
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            p = $urandom_range(0, 99);
            e = (r >= 8);
            pm = 1'b0; ps = 1'b0; pst = 1'b0; pcl = 1'b0;
            if (p < 1)       pm = 1'b1;
            else if (p < 8)  ps = 1'b1;
            else if (p < 11) pst = 1'b1;
            else if (p == 11) pcl = 1'b1;
            else if (p == 12) begin pcl = 1'b1; pst = 1'b1; end
            step(e, pm, ps, pst, pcl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
